// File: rtl/uart_tx8.sv
// rtl/uart_tx8.sv - 8N1 UART transmitter with a one-byte holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx8 #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txReady,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          bit_end;
  logic          load;

  assign bit_end = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + BW'(1);
    done_d     = 1'b0;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (hold_vld_q && txEn) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (hold_vld_q && txEn) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d    = hold_q;
      hold_vld_d = 1'b0;
      bit_cnt_d  = 3'd0;
`ifdef UART_TX_PARITY_EN
      par_d      = ^hold_q;
`endif
    end

    // Accept and load are mutually exclusive: load needs a full register, accept an empty one.
    if (txStart && !hold_vld_q) begin
      hold_d     = in;
      hold_vld_d = 1'b1;
    end

    // Line outputs follow the registered state, so tx/busy/done stay mutually aligned.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      baud_cnt_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign txReady = ~hold_vld_q;
  assign txBusy  = busy_q;
  assign txDone  = done_q;
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx8.sv
// tb/tb_uart_tx8.sv - scoreboard bench for uart_tx8: directed bytes, line decoder monitor.
module tb_uart_tx8;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       txEn = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] in_b = 8'h00;
  logic       txReady, txBusy, txDone, tx;

  uart_tx8 #(.CLOCK_RATE(CPB * 9600), .BAUD_RATE(9600)) dut (
    .clk(clk), .rstn(rstn), .txEn(txEn), .txStart(txStart), .in(in_b),
    .txReady(txReady), .txBusy(txBusy), .txDone(txDone), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; bit b2b; } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int n_push = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (txDone === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit b2b);
    exp_t e;
    e.b = b;
    e.b2b = b2b;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic send(input logic [7:0] b, output bit acc);
    @(negedge clk);
    acc = txReady;
    in_b = b;
    txStart = 1'b1;
    @(posedge clk);
    #1 txStart = 1'b0;
  endtask

  task automatic send_when_ready(input logic [7:0] b, input string name);
    int n = 0;
    bit acc;
    @(negedge clk);
    while (txReady !== 1'b1 && n < 30 * CPB) begin
      @(negedge clk);
      n++;
    end
    send(b, acc);
    check(name, acc, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(posedge clk);
    #1;
    while (txDone !== 1'b1 && n < 30 * CPB) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, txDone, 1'b1);
  endtask

  task automatic tx_low_latency(output int n);
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Decodes every frame on the line and pops the scoreboard.
  initial begin : monitor
    int start_cyc;
    int prev_start;
    logic [10:0] bits;
    bit glitch, early_done, last_done;
    exp_t e;
    prev_start = -100000;
    forever begin
      @(negedge clk);
      if (mon_en && rstn && tx === 1'b0) begin
        start_cyc = cyc;
        bits = '0;
        glitch = 1'b0;
        early_done = 1'b0;
        last_done = 1'b0;
        for (int k = 0; k < NB; k++) begin
          for (int c = 0; c < CPB; c++) begin
            if (!(k == 0 && c == 0)) @(negedge clk);
            if (c == 0) bits[k] = tx;
            else if (tx !== bits[k]) glitch = 1'b1;
            if (k == NB - 1 && c == CPB - 1) last_done = txDone;
            else if (txDone === 1'b1) early_done = 1'b1;
          end
        end
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {24'h0, bits[8:1]}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", bits[8:1], e.b);
          check("stop_bit", bits[NB-1], 1'b1);
          check("bit_stable", glitch, 1'b0);
          check("done_not_early", early_done, 1'b0);
          check("done_at_stop_end", last_done, 1'b1);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", bits[9], ^e.b);
`endif
          if (e.b2b) check("back_to_back_gap", start_cyc - prev_start, NB * CPB);
        end
        prev_start = start_cyc;
      end
    end
  end

  initial begin : watchdog
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    int n, lows, dones;

    // Reset values, then reset in the middle of a START bit.
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", txBusy, 1'b0);
    check("rst_done", txDone, 1'b0);
    check("rst_ready", txReady, 1'b1);
    rstn = 1'b1;
    txEn = 1'b1;
    send(8'h12, acc);
    repeat (CPB / 2) @(posedge clk);
    #1 check("pre_rst_tx_low", tx, 1'b0);
    #1 rstn = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", txBusy, 1'b0);
    check("async_rst_ready", txReady, 1'b1);
    check("async_rst_done", txDone, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    lows = 0;
    dones = 0;
    repeat (12 * CPB) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lows++;
      if (txDone !== 1'b0) dones++;
    end
    check("post_rst_line_quiet", lows, 0);
    check("post_rst_no_done", dones, 0);
    mon_en = 1'b1;

    // Single frame, start latency and busy drop.
    push(8'b0101_0110, 1'b0);
    send(8'b0101_0110, acc);
    check("accept_56", acc, 1'b1);
    tx_low_latency(n);
    check("start_latency", n, 2);
    wait_done("done_56");
    @(posedge clk);
    #1;
    check("busy_drop", txBusy, 1'b0);
    check("ready_idle", txReady, 1'b1);

    // Back-to-back frames via the holding register.
    push(8'hA5, 1'b0);
    send(8'hA5, acc);
    check("accept_A5", acc, 1'b1);
    repeat (CPB + 8) @(posedge clk);
    push(8'h3C, 1'b1);
    send(8'h3C, acc);
    check("accept_3C", acc, 1'b1);
    wait_done("done_A5");
    wait_done("done_3C");

    // Start while holding register full is dropped.
    txEn = 1'b0;
    push(8'h00, 1'b0);
    send(8'h00, acc);
    check("accept_00", acc, 1'b1);
    send(8'hFF, acc);
    check("reject_FF", acc, 1'b0);
    txEn = 1'b1;
    wait_done("done_00");

    // Held byte waits for txEn.
    txEn = 1'b0;
    push(8'h81, 1'b0);
    send(8'h81, acc);
    check("accept_81", acc, 1'b1);
    lows = 0;
    repeat (3 * CPB) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lows++;
    end
    check("txen_low_line_idle", lows, 0);
    check("txen_low_held", txReady, 1'b0);
    @(negedge clk);
    txEn = 1'b1;
    tx_low_latency(n);
    check("txen_start_latency", n, 2);
    wait_done("done_81");

    // Streams of bytes, including a restart right after a frame ends.
    push(8'h00, 1'b0);
    send(8'h00, acc);
    check("accept_s00", acc, 1'b1);
    push(8'hFF, 1'b1);
    send_when_ready(8'hFF, "accept_sFF");
    wait_done("done_s00");
    push(8'h56, 1'b1);
    send_when_ready(8'h56, "accept_s56");
    wait_done("done_sFF");
    wait_done("done_s56");
    push(8'h57, 1'b0);
    send(8'h57, acc);
    check("accept_s57", acc, 1'b1);
    wait_done("done_s57");

    repeat (4 * CPB) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_count", done_cnt, n_push);
    check("final_tx_idle", tx, 1'b1);
    check("final_busy", txBusy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
